// File: rtl/fifo_pkg.sv
// Shared definitions for the queue blocks: read-mode encodings and the
// occupancy-counter width helper.
package fifo_pkg;

    localparam int unsigned FIFO_MODE_REG  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Enough bits to hold every value 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Push/pop handshake, data and status bundle of sync_fifo_flags.
// The master drives requests; the slave (the FIFO) returns data and flags.
interface sync_fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int unsigned bitWidth    = 32,
    parameter int unsigned nrOfEntries = 16
) ();

    localparam int unsigned CountWidth = count_width(nrOfEntries);

    logic                  push;
    logic [bitWidth-1:0]   pushData;
    logic                  pop;
    logic [bitWidth-1:0]   popData;
    logic                  popValid;
    logic                  full;
    logic                  empty;
    logic                  almostFull;
    logic                  almostEmpty;
    logic [CountWidth-1:0] count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pushData, pop,
        input  popData, popValid, full, empty, almostFull, almostEmpty, count,
               overflow, underflow
    );

    modport slave (
        input  push, pushData, pop,
        output popData, popValid, full, empty, almostFull, almostEmpty, count,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_wrap_pointer.sv
// Modulo-LIMIT up-counter with synchronous reset and enable; wraps from
// LIMIT-1 to 0 so FIFO depths need not be powers of two.
module fifo_wrap_pointer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LIMIT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (enable) begin
            value_d = (value_q == WIDTH'(LIMIT - 1)) ? '0 : value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO using every entry, with occupancy count, almost-full/empty
// thresholds, overflow/underflow pulses and a FWFT or registered read port.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned nrOfEntries      = 16,
    parameter int unsigned bitWidth         = 32,
    parameter int unsigned almostFullLevel  = 12,
    parameter int unsigned almostEmptyLevel = 4,
    parameter int unsigned fwftMode         = 1
) (
    input logic               clock,
    input logic               reset,
    sync_fifo_flags_if.slave  bus
);

    localparam int unsigned PtrWidth   = $clog2(nrOfEntries);
    localparam int unsigned CountWidth = count_width(nrOfEntries);

    if (nrOfEntries < 2 || bitWidth < 1 || almostFullLevel < 1 ||
        almostFullLevel > nrOfEntries || almostEmptyLevel > nrOfEntries - 1 ||
        (fwftMode != FIFO_MODE_REG && fwftMode != FIFO_MODE_FWFT)) begin : gen_param_check
        $fatal(1, "sync_fifo_flags: illegal parameter combination");
    end

    logic                  push_acc, pop_acc;
    logic                  full, empty;
    logic [PtrWidth-1:0]   wr_ptr, rd_ptr;
    logic [CountWidth-1:0] count_q, count_d;
    logic [bitWidth-1:0]   mem_q [nrOfEntries];
    logic [bitWidth-1:0]   pop_data_q;
    logic                  pop_valid_q, overflow_q, underflow_q;

    assign full     = count_q == CountWidth'(nrOfEntries);
    assign empty    = count_q == '0;
    assign pop_acc  = bus.pop && !empty;
    // A pop in the same cycle frees the head slot, so a full FIFO still takes the push.
    assign push_acc = bus.push && (!full || pop_acc);

    fifo_wrap_pointer #(
        .WIDTH (PtrWidth),
        .LIMIT (nrOfEntries)
    ) u_wr_ptr (
        .clock  (clock),
        .reset  (reset),
        .enable (push_acc),
        .value  (wr_ptr)
    );

    fifo_wrap_pointer #(
        .WIDTH (PtrWidth),
        .LIMIT (nrOfEntries)
    ) u_rd_ptr (
        .clock  (clock),
        .reset  (reset),
        .enable (pop_acc),
        .value  (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CountWidth'(1);
            2'b01:   count_d = count_q - CountWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_valid_q <= pop_acc;
            overflow_q  <= bus.push && !push_acc;
            underflow_q <= bus.pop && !pop_acc;
            if (pop_acc) begin
                pop_data_q <= mem_q[rd_ptr];
            end
        end
    end

    // Storage is not reset; only occupied entries are ever read.
    always_ff @(posedge clock) begin
        if (!reset && push_acc) begin
            mem_q[wr_ptr] <= bus.pushData;
        end
    end

    assign bus.popData     = (fwftMode == FIFO_MODE_FWFT) ? (empty ? '0 : mem_q[rd_ptr])
                                                          : pop_data_q;
    assign bus.popValid    = (fwftMode == FIFO_MODE_FWFT) ? !empty : pop_valid_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostFull  = count_q >= CountWidth'(almostFullLevel);
    assign bus.almostEmpty = count_q <= CountWidth'(almostEmptyLevel);
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock parametrised FIFO for streaming data between pipeline stages in the lab SoC.
- Every entry is usable (nrOfEntries entries, not nrOfEntries-1); depth need not be a power of two.
- Provides an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a selectable read mode: first-word-fall-through or registered read.

Parameters:
nrOfEntries, 16, storage depth; any integer >= 2.
bitWidth, 32, data width in bits; >= 1.
almostFullLevel, 12, almostFull asserts when count >= this value; range 1..nrOfEntries.
almostEmptyLevel, 4, almostEmpty asserts when count <= this value; range 0..nrOfEntries-1.
fwftMode, 1, 1 = first-word-fall-through; 0 = registered read with popValid.

Ports:
clock  input  1  single clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
push  input  1  write request.
pushData  input  bitWidth  data written when push is accepted.
pop  input  1  read request.
popData  output  bitWidth  read data (see Behaviour).
popValid  output  1  fwftMode=0: popData valid this cycle; fwftMode=1: equals !empty.
full  output  1  count == nrOfEntries.
empty  output  1  count == 0.
almostFull  output  1  count >= almostFullLevel.
almostEmpty  output  1  count <= almostEmptyLevel.
count  output  $clog2(nrOfEntries+1)  current occupancy.
overflow  output  1  one-cycle pulse: push rejected.
underflow  output  1  one-cycle pulse: pop rejected.

Behaviour:
- Reset, sampled on the clock edge, has priority over all other inputs.
  - Pointers and count go to 0; empty=1, almostEmpty=1; full, almostFull, popValid, overflow and underflow go to 0; popData goes to 0.
  - Stored contents are don't-care after reset.
- Accept rules:
  - pushAcc = push && (!full || popAcc).
  - popAcc = pop && !empty.
  - A push+pop while full is accepted for both: count unchanged, the head leaves and the new word enters.
  - A push+pop while empty accepts only the push; underflow pulses.
- Count update, per edge: +1 on push only, -1 on pop only, unchanged on both or neither. All flags are derived combinationally from the registered count.
- Pointers: write and read pointers of width $clog2(nrOfEntries).
  - Each increments on its accept and wraps from nrOfEntries-1 to 0 (modulo, not power-of-two rollover).
- overflow = push && !pushAcc, registered so it is high for exactly the following cycle. underflow uses the same rule with pop.
- fwftMode=1:
  - popData always shows the head entry while !empty and is don't-care while empty.
  - A word pushed into an empty FIFO at edge t is visible on popData and empty=0 after edge t (zero-bubble).
  - popAcc at edge t presents the next entry after edge t.
- fwftMode=0:
  - popAcc at edge t loads the head into the popData register; popValid=1 for the cycle after t.
  - popData holds its value until the next popAcc; popValid=0 on cycles with no preceding popAcc.
- Storage is a flop/LUT array with a combinational read. Writes to an entry and reads from it do not collide, because reads only address occupied entries.
- Reset asserted mid-stream discards all data. Inputs in the reset cycle are ignored, including push and pop.
- Illegal parameter values (range violations above) stop elaboration via a generate-time check.

Decomposition:
- Shared package fifo_pkg: read-mode constants FIFO_MODE_REG=0 and FIFO_MODE_FWFT=1, plus a count-width helper function (clog2 of depth+1) reused by other queue blocks.
- One sub-module, fifo_wrap_pointer: a modulo-N up-counter with synchronous reset, an enable, and a WIDTH/LIMIT parameter.
  - Instantiated twice, once for the write pointer and once for the read pointer.
  - Replaces the plain rollover counter so non-power-of-two depths work.

Test Plan:
- nrOfEntries=16, fwftMode=1: push 0x00..0x0F on 16 consecutive cycles with no pops -> full=1 after the 16th edge, count=16, almostFull=1 from count 12. A 17th push gives overflow=1 for one cycle and count stays 16. Then pop 16 -> popData sequence 0x00..0x0F, empty=1, count=0.
- Empty FIFO with push=1 (data 0xA5) and pop=1 in the same cycle -> underflow=1 for one cycle, count=1, popData=0xA5 next cycle, empty=0.
- Full FIFO with push (0xBEEF) and pop together for 20 cycles -> count stays 16, no overflow, output order preserved across pointer wrap.
- nrOfEntries=5 (non-power-of-two): push 1..5, pop 3, push 6..8, pop 5 -> popData 1,2,3,4,5,6,7,8; full asserts at count 5 only.
- fwftMode=0: push 0x11, 0x22; pop on one cycle -> the next cycle shows popValid=1 and popData=0x11. popValid=0 the cycle after that, with popData still 0x11.
- Reset asserted with count=7 while push=1 and pop=1 -> next cycle count=0, empty=1, popValid=0, overflow=0 and underflow=0; the push in the reset cycle is not stored.
